// File: rtl/ariane_bitmanip_crc_unit.sv
// Iterative CRC32 / CRC32C functional unit for the Bitmanip execute cluster.
// Accepts one request in IDLE, shifts BITS_PER_CYCLE bits per clock in BUSY,
// and presents the result for a single cycle in DONE.
module ariane_bitmanip_crc_unit #(
  parameter int XLEN           = 64,
  parameter int TRANS_ID_BITS  = 3,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [8:0]               operator_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     result_valid_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          CNT_SHIFT   = $clog2(BITS_PER_CYCLE);
  localparam logic [31:0] POLY_CRC32  = 32'hEDB88320;
  localparam logic [31:0] POLY_CRC32C = 32'h82F63B78;

  // Only power-of-two step counts that divide 8 keep the cycle count integral.
  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bits_per_cycle
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  // One reflected CRC shift: drop the LSB and fold the polynomial in when it was set.
  function automatic logic [XLEN-1:0] crc_step(input logic [XLEN-1:0] x,
                                               input logic [31:0]     poly);
    logic [XLEN-1:0] mask;
    mask = {XLEN{x[0]}};
    return (x >> 1) ^ ({{(XLEN-32){1'b0}}, poly} & mask);
  endfunction

  state_e                   state_r;
  logic [XLEN-1:0]          x_r;
  logic [31:0]              poly_r;
  logic [7:0]               cnt_r;
  logic [TRANS_ID_BITS-1:0] id_r;
  logic                     ready_r;
  logic                     result_valid_r;
  logic [XLEN-1:0]          result_r;
  logic [TRANS_ID_BITS-1:0] result_id_r;

  logic [XLEN-1:0]          x_next_s;
  logic [7:0]               nbits_s;
  logic [7:0]               load_cnt_s;
  logic                     unused_s;

  // Operator bits above the size/variant fields carry no meaning for this unit.
  assign unused_s = ^operator_i[8:3];

  // Cycle count for the request on the issue port: (8 << size) / BITS_PER_CYCLE.
  always_comb begin
    nbits_s    = 8'd8 << operator_i[1:0];
    load_cnt_s = nbits_s >> CNT_SHIFT;
  end

  // Chain BITS_PER_CYCLE shift steps on the working value within one clock.
  always_comb begin
    x_next_s = x_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      x_next_s = crc_step(x_next_s, poly_r);
    end
  end

  // Control FSM with datapath and registered outputs; flush overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r        <= IDLE;
      x_r            <= {XLEN{1'b0}};
      poly_r         <= 32'd0;
      cnt_r          <= 8'd0;
      id_r           <= {TRANS_ID_BITS{1'b0}};
      ready_r        <= 1'b1;
      result_valid_r <= 1'b0;
      result_r       <= {XLEN{1'b0}};
      result_id_r    <= {TRANS_ID_BITS{1'b0}};
    end else if (flush_i) begin
      state_r        <= IDLE;
      cnt_r          <= 8'd0;
      ready_r        <= 1'b1;
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            x_r     <= operand_a_i;
            poly_r  <= operator_i[2] ? POLY_CRC32C : POLY_CRC32;
            id_r    <= trans_id_i;
            cnt_r   <= load_cnt_s;
            ready_r <= 1'b0;
            state_r <= BUSY;
          end else begin
            ready_r <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_r == 8'd1) begin
            result_r       <= x_next_s;
            result_id_r    <= id_r;
            result_valid_r <= 1'b1;
            cnt_r          <= 8'd0;
            state_r        <= DONE;
          end else begin
            x_r   <= x_next_s;
            cnt_r <= cnt_r - 8'd1;
          end
        end
        DONE: begin
          result_valid_r <= 1'b0;
          ready_r        <= 1'b1;
          state_r        <= IDLE;
        end
        default: begin
          result_valid_r <= 1'b0;
          ready_r        <= 1'b1;
          cnt_r          <= 8'd0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  assign ready_o           = ready_r;
  // A flush landing in the DONE cycle must suppress the strobe in that same cycle.
  assign result_valid_o    = result_valid_r & ~flush_i;
  assign result_o          = result_r;
  assign result_trans_id_o = result_id_r;

endmodule

// File: tb/tb_ariane_bitmanip_crc_unit.sv
// Self-checking bench: behavioural CRC/timing model plus per-cycle compare.
module tb_ariane_bitmanip_crc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        valid1 = 1'b0;
  logic [8:0]  op_in = 9'd0;
  logic [63:0] a_in = 64'd0;
  logic [2:0]  id_in = 3'd0;

  logic        ready, rv, ready1, rv1;
  logic [63:0] res, res1;
  logic [2:0]  rid, rid1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit          pend = 1'b0;
  int          exp_cyc = 0;
  int          next_acc = 0;
  logic [63:0] exp_res = 64'd0;
  logic [2:0]  exp_id = 3'd0;

  always #5 clk = ~clk;

  ariane_bitmanip_crc_unit #(.XLEN(64), .TRANS_ID_BITS(3), .BITS_PER_CYCLE(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(ready),
    .operator_i(op_in), .operand_a_i(a_in), .trans_id_i(id_in),
    .result_o(res), .result_valid_o(rv), .result_trans_id_o(rid));

  ariane_bitmanip_crc_unit #(.XLEN(64), .TRANS_ID_BITS(3), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid1), .ready_o(ready1),
    .operator_i(op_in), .operand_a_i(a_in), .trans_id_i(id_in),
    .result_o(res1), .result_valid_o(rv1), .result_trans_id_o(rid1));

  // Reference CRC straight from the definition: nbits reflected shifts over 64 bits.
  function automatic logic [63:0] crc_model(input logic [8:0] op, input logic [63:0] a);
    logic [63:0] x;
    logic [63:0] p;
    int n;
    x = a;
    p = op[2] ? 64'h0000_0000_82F6_3B78 : 64'h0000_0000_EDB8_8320;
    n = 8 << op[1:0];
    for (int i = 0; i < n; i++) x = x[0] ? ((x >> 1) ^ p) : (x >> 1);
    return x;
  endfunction

  function automatic int cycles_for(input logic [8:0] op, input int bpc);
    return (8 << op[1:0]) / bpc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing/result model advanced at each active edge from the sampled inputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend     = 1'b0;
      next_acc = 0;
    end else begin
      if (pend && cyc == exp_cyc) pend = 1'b0;
      if (flush) begin
        pend = 1'b0;
        if (next_acc > cyc + 1) next_acc = cyc + 1;
      end else if (cyc >= next_acc && valid) begin
        pend     = 1'b1;
        exp_cyc  = cyc + cycles_for(op_in, 8) + 1;
        exp_res  = crc_model(op_in, a_in);
        exp_id   = id_in;
        next_acc = cyc + cycles_for(op_in, 8) + 2;
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of the BITS_PER_CYCLE=8 instance against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", {63'd0, ready}, 64'd1);
      chk("rst_rvalid", {63'd0, rv}, 64'd0);
      chk("rst_result", res, 64'd0);
      chk("rst_id", {61'd0, rid}, 64'd0);
    end else begin
      chk("ready", {63'd0, ready}, {63'd0, (cyc >= next_acc)});
      chk("rvalid", {63'd0, rv}, {63'd0, (pend && cyc == exp_cyc && !flush)});
      if (pend && cyc == exp_cyc && !flush) begin
        chk("result", res, exp_res);
        chk("res_id", {61'd0, rid}, {61'd0, exp_id});
      end
    end
  end

  task automatic issue(input logic [8:0] op, input logic [63:0] a, input logic [2:0] id,
                       input logic [63:0] lit, input string name);
    bit got;
    int lat;
    @(posedge clk); #1;
    valid = 1'b1; op_in = op; a_in = a; id_in = id;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready) begin got = 1'b1; break; end
    end
    chk({name, "_accept"}, {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (rv) begin got = 1'b1; lat = k; break; end
    end
    chk({name, "_done"}, {63'd0, got}, 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'(cycles_for(op, 8) + 1));
    chk({name, "_value"}, res, lit);
    chk({name, "_id"}, {61'd0, rid}, {61'd0, id});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [2];
    int n_acc;
    bit got;
    int lat;
    logic [63:0] a_rand;

    // model pins
    chk("pin_crc32b_1", crc_model(9'h000, 64'h1), 64'h77073096);
    chk("pin_crc32b_ff", crc_model(9'h000, 64'hFF), 64'h2D02EF8D);
    chk("pin_crc32cb_1", crc_model(9'h004, 64'h1), 64'hF26B8303);
    chk("pin_crc32cb_80", crc_model(9'h004, 64'h80), 64'h82F63B78);
    chk("pin_crc32h_10000", crc_model(9'h001, 64'h10000), 64'h1);

    #22 rst_n = 1'b1;

    // directed single requests with literal results
    issue(9'h000, 64'h1, 3'd5, 64'h77073096, "crc32b_1");
    issue(9'h000, 64'hFF, 3'd1, 64'h2D02EF8D, "crc32b_ff");
    issue(9'h004, 64'h1, 3'd2, 64'hF26B8303, "crc32cb_1");
    issue(9'h004, 64'h80, 3'd3, 64'h82F63B78, "crc32cb_80");
    issue(9'h000, 64'h100, 3'd4, 64'h1, "crc32b_100");
    issue(9'h001, 64'h10000, 3'd6, 64'h1, "crc32h_10000");
    issue(9'h003, 64'h0, 3'd7, 64'h0, "crc32d_0");
    issue(9'h1F8, 64'h1, 3'd0, 64'h77073096, "crc32b_hibits");

    // valid held across two crc32.h requests: second accept at first+N+2
    @(posedge clk); #1;
    valid = 1'b1; op_in = 9'h001; a_in = 64'h1234_5678_9ABC_DEF0; id_in = 3'd2;
    n_acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) begin acc[n_acc] = cyc; n_acc++; if (n_acc == 2) break; end
    end
    @(posedge clk); #1;
    valid = 1'b0;
    chk("b2b_count", 64'(n_acc), 64'd2);
    if (n_acc == 2) chk("b2b_spacing", 64'(acc[1] - acc[0]), 64'd4);
    repeat (6) @(posedge clk);

    // flush in the 3rd BUSY cycle of crc32.w
    @(posedge clk); #1;
    valid = 1'b1; op_in = 9'h002; a_in = 64'hDEAD_BEEF; id_in = 3'd3;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) begin got = 1'b1; break; end
    end
    chk("flush_accept", {63'd0, got}, 64'd1);
    @(posedge clk); #1 valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready_next", {63'd0, ready}, 64'd1);
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv) got = 1'b1;
    end
    chk("flush_no_result", {63'd0, got}, 64'd0);
    issue(9'h006, 64'hCAFE_F00D, 3'd5, crc_model(9'h006, 64'hCAFE_F00D), "after_flush");

    // BITS_PER_CYCLE=1 instance: crc32.d latency 65
    a_rand = {$urandom, $urandom};
    @(posedge clk); #1;
    valid1 = 1'b1; op_in = 9'h003; a_in = a_rand; id_in = 3'd6;
    @(negedge clk);
    chk("bpc1_ready", {63'd0, ready1}, 64'd1);
    @(posedge clk); #1 valid1 = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rv1) begin got = 1'b1; lat = k; break; end
    end
    chk("bpc1_done", {63'd0, got}, 64'd1);
    chk("bpc1_latency", 64'(lat), 64'd65);
    chk("bpc1_value", res1, crc_model(9'h003, a_rand));
    chk("bpc1_id", {61'd0, rid1}, 64'd6);
    repeat (3) @(posedge clk);

    // asynchronous reset mid-BUSY
    @(posedge clk); #1;
    valid = 1'b1; op_in = 9'h003; a_in = 64'h1; id_in = 3'd4;
    @(negedge clk);
    @(posedge clk); #1 valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {63'd0, ready}, 64'd1);
    chk("async_rst_rvalid", {63'd0, rv}, 64'd0);
    chk("async_rst_result", res, 64'd0);
    chk("async_rst_id", {61'd0, rid}, 64'd0);
    @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (15) @(posedge clk);

    // randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      valid = ($urandom_range(0, 3) != 0);
      op_in = 9'($urandom);
      a_in  = {$urandom, $urandom};
      id_in = 3'($urandom);
      flush = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    flush = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
